// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dmem_arbiter_if                                            |
// | Brief    : Two-requester data-memory bus plus memory-side port.       |
// | Revision : 1.0                                                       |
// +-----------------------------------------------------------------------+
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_lock;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_lock;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;
    logic              locked;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_we, mem_addr, mem_wdata,
        output owner, locked
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  owner, locked
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dmem_arbiter                                               |
// | Brief    : Round-robin 2:1 data-memory arbiter with bounded locking.  |
// | Revision : 1.0                                                       |
// +-----------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [7:0] c_MAX_LOCK = 8'(MAX_LOCK);

    logic              r_owner;
    logic              r_locked;
    logic [7:0]        r_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_lock_in;
    logic [7:0]        w_cnt_inc;

    // While locked only the owner may win; otherwise contention goes to the non-owner.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (r_locked) begin
                w_gnt0 = bus.r0_req && !r_owner;
                w_gnt1 = bus.r1_req &&  r_owner;
            end else if (bus.r0_req && bus.r1_req) begin
                w_gnt0 =  r_owner;
                w_gnt1 = !r_owner;
            end else begin
                w_gnt0 = bus.r0_req;
                w_gnt1 = bus.r1_req;
            end
        end
    end

    always_comb begin
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_lock_in = 1'b0;
        if (w_gnt0) begin
            w_we      = bus.r0_we;
            w_addr    = bus.r0_addr;
            w_wdata   = bus.r0_wdata;
            w_lock_in = bus.r0_lock;
        end else if (w_gnt1) begin
            w_we      = bus.r1_we;
            w_addr    = bus.r1_addr;
            w_wdata   = bus.r1_wdata;
            w_lock_in = bus.r1_lock;
        end
    end

    assign w_any     = w_gnt0 || w_gnt1;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= 1'b1;
            r_locked  <= 1'b0;
            r_cnt     <= 8'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !bus.r0_we;
            r_rvalid1 <= w_gnt1 && !bus.r1_we;
            if (w_gnt0 && !bus.r0_we) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_gnt1 && !bus.r1_we) begin
                r_rdata1 <= bus.mem_rdata;
            end
            if (w_any) begin
                r_owner <= w_gnt1;
            end
            // A locked grant continues only while lock is held and the cap is not reached.
            if (r_locked) begin
                if (w_any && w_lock_in && (w_cnt_inc != c_MAX_LOCK)) begin
                    r_cnt <= w_cnt_inc;
                end else begin
                    r_locked <= 1'b0;
                    r_cnt    <= 8'd0;
                end
            end else if (w_any && w_lock_in && (c_MAX_LOCK != 8'd1)) begin
                r_locked <= 1'b1;
                r_cnt    <= 8'd1;
            end
        end
    end

    assign bus.r0_gnt    = w_gnt0;
    assign bus.r1_gnt    = w_gnt1;
    assign bus.r0_rvalid = r_rvalid0;
    assign bus.r1_rvalid = r_rvalid1;
    assign bus.r0_rdata  = r_rdata0;
    assign bus.r1_rdata  = r_rdata1;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.owner     = r_owner;
    assign bus.locked    = r_locked;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                            |
// | Brief    : Directed vector bench for dmem_arbiter with memory model.  |
// | Revision : 1.0                                                       |
// +-----------------------------------------------------------------------+
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    logic mem_init;
    int   n_chk;
    int   n_pass;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten word i reads 0x1000_0000 + i.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    typedef struct {
        logic        rst;
        logic        q0, w0, l0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        q1, w1, l1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic        eg0, eg1, ev0, ev1;
        logic [31:0] er0, er1;
        logic        eown, elck;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic r,
        input logic q0, input logic w0, input logic l0, input logic [9:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [9:0] a1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ev0, input logic ev1,
        input logic [31:0] er0, input logic [31:0] er1, input logic eown, input logic elck);
        vec_t t;
        t.rst = r;
        t.q0 = q0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.d0 = d0;
        t.q1 = q1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.d1 = d1;
        t.eg0 = eg0; t.eg1 = eg1; t.ev0 = ev0; t.ev1 = ev1;
        t.er0 = er0; t.er1 = er1; t.eown = eown; t.elck = elck;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(
        input logic q0, input logic w0, input logic l0, input logic [9:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [9:0] a1, input logic [31:0] d1);
        bus.r0_req = q0; bus.r0_we = w0; bus.r0_lock = l0; bus.r0_addr = a0; bus.r0_wdata = d0;
        bus.r1_req = q1; bus.r1_we = w1; bus.r1_lock = l1; bus.r1_addr = a1; bus.r1_wdata = d1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0);
    endtask

    initial begin
        logic        ewe;
        logic [9:0]  eaddr;
        logic [31:0] ewd;
        n_chk = 0;
        n_pass = 0;

        // rst,  r0: q w l addr data,          r1: q w l addr data,     g0 g1 v0 v1, rd0 rd1, own lck
        tbl.push_back(v(1, 1,1,0,10'd5,32'hA5A5_0001, 1,0,0,10'd7,0, 0,0,0,0, 32'h0, 32'h0, 1,0));
        tbl.push_back(v(0, 1,1,0,10'd5,32'hA5A5_0001, 0,0,0,10'd0,0, 1,0,0,0, 32'h0, 32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'd5,0,             0,0,0,10'd0,0, 1,0,0,0, 32'h0, 32'h0, 0,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             0,0,0,10'd0,0, 0,0,1,0, 32'hA5A5_0001, 32'h0, 0,0));
        tbl.push_back(v(1, 0,0,0,10'd0,0,             0,0,0,10'd0,0, 0,0,0,0, 32'hA5A5_0001, 32'h0, 0,0));
        tbl.push_back(v(0, 1,0,0,10'd5,0,             1,0,0,10'd7,0, 1,0,0,0, 32'h0, 32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'd6,0,             1,0,0,10'd7,0, 0,1,1,0, 32'hA5A5_0001, 32'h0, 0,0));
        tbl.push_back(v(0, 1,0,0,10'd6,0,             1,0,0,10'd8,0, 1,0,0,1, 32'hA5A5_0001, 32'h1000_0007, 1,0));
        tbl.push_back(v(0, 1,0,0,10'd9,0,             1,0,0,10'd8,0, 0,1,1,0, 32'h1000_0006, 32'h1000_0007, 0,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             0,0,0,10'd0,0, 0,0,0,1, 32'h1000_0006, 32'h1000_0008, 1,0));
        tbl.push_back(v(0, 1,0,0,10'd3,0,             1,0,1,10'd10,0, 1,0,0,0, 32'h1000_0006, 32'h1000_0008, 1,0));
        tbl.push_back(v(0, 1,0,0,10'd4,0,             1,0,1,10'd10,0, 0,1,1,0, 32'h1000_0003, 32'h1000_0008, 0,0));
        for (int k = 12; k <= 18; k++)
            tbl.push_back(v(0, 1,0,0,10'd4,0, 1,0,1,10'(k-1),0, 0,1,0,1,
                            32'h1000_0003, 32'h1000_0000 + 32'(k-2), 1,1));
        tbl.push_back(v(0, 1,0,0,10'd4,0,             1,0,1,10'd18,0, 1,0,0,1, 32'h1000_0003, 32'h1000_0011, 1,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             1,0,0,10'd18,0, 0,1,1,0, 32'h1000_0004, 32'h1000_0011, 0,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             0,0,0,10'd0,0, 0,0,0,1, 32'h1000_0004, 32'h1000_0012, 1,0));
        tbl.push_back(v(0, 1,1,0,10'd1023,32'hFFFF_FFFF, 0,0,0,10'd0,0, 1,0,0,0, 32'h1000_0004, 32'h1000_0012, 1,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             1,0,0,10'd1023,0, 0,1,0,0, 32'h1000_0004, 32'h1000_0012, 0,0));
        tbl.push_back(v(0, 0,0,0,10'd0,0,             0,0,0,10'd0,0, 0,0,0,1, 32'h1000_0004, 32'hFFFF_FFFF, 1,0));

        rst = 1'b1;
        mem_init = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            set_in(tbl[i].q0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                   tbl[i].q1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            #1;
            ewe   = (tbl[i].eg0 && tbl[i].w0) || (tbl[i].eg1 && tbl[i].w1);
            eaddr = tbl[i].eg0 ? tbl[i].a0 : (tbl[i].eg1 ? tbl[i].a1 : 10'd0);
            ewd   = tbl[i].eg0 ? tbl[i].d0 : (tbl[i].eg1 ? tbl[i].d1 : 32'd0);
            chk($sformatf("row%0d gnt", i),      {bus.r0_gnt, bus.r1_gnt},       {tbl[i].eg0, tbl[i].eg1});
            chk($sformatf("row%0d rvalid", i),   {bus.r0_rvalid, bus.r1_rvalid}, {tbl[i].ev0, tbl[i].ev1});
            chk($sformatf("row%0d r0_rdata", i), bus.r0_rdata,                   tbl[i].er0);
            chk($sformatf("row%0d r1_rdata", i), bus.r1_rdata,                   tbl[i].er1);
            chk($sformatf("row%0d own/lck", i),  {bus.owner, bus.locked},        {tbl[i].eown, tbl[i].elck});
            chk($sformatf("row%0d mem bus", i),  {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {ewe, eaddr, ewd});
            @(negedge clk);
        end

        // r0 takes a lock, then drops req: r1 must wait one cycle, then win.
        set_in(1, 0, 1, 10'd20, 0, 0, 0, 0, 10'd0, 0);
        #1 chk("idle-lock grant r0", {bus.r0_gnt, bus.r1_gnt}, 2'b10);
        @(negedge clk);
        set_in(0, 0, 0, 10'd0, 0, 1, 0, 0, 10'd21, 0);
        #1 chk("idle-lock r1 blocked", {bus.r0_gnt, bus.r1_gnt, bus.locked}, 3'b001);
        @(negedge clk);
        #1 chk("idle-lock released", {bus.r1_gnt, bus.locked}, 2'b10);
        @(negedge clk);
        idle();
        #1 chk("idle-lock r1 data", {bus.r1_rvalid, bus.r1_rdata}, {1'b1, 32'h1000_0015});
        @(negedge clk);

        // r1 locked read, then reset lands on the edge ending the next read grant.
        set_in(0, 0, 0, 10'd0, 0, 1, 0, 1, 10'd22, 0);
        @(negedge clk);
        set_in(0, 0, 0, 10'd0, 0, 1, 0, 1, 10'd23, 0);
        #1 chk("pre-reset state", {bus.r1_gnt, bus.locked, bus.r1_rvalid, bus.r1_rdata},
               {3'b111, 32'h1000_0016});
        #1 rst = 1'b1;
        #1 chk("gnt gated in reset", {bus.r0_gnt, bus.r1_gnt, bus.mem_we}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 0, 0, 10'd30, 0, 1, 0, 0, 10'd31, 0);
        #1 chk("post-reset rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
        chk("post-reset rdata", {bus.r0_rdata, bus.r1_rdata}, 64'd0);
        chk("post-reset own/lck", {bus.owner, bus.locked}, 2'b10);
        chk("post-reset r0 first", {bus.r0_gnt, bus.r1_gnt}, 2'b10);
        @(negedge clk);
        #1 chk("post-reset r1 next", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid}, 3'b011);
        @(negedge clk);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
